exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits.
REQ-002 Parameter MUL_BITS, default 1: multiplier bits retired per cycle; XLEN % MUL_BITS == 0; MUL_CYCLES = XLEN/MUL_BITS.
REQ-003 Ports, in order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- optype  in  5  shared instruction code (I_* set).
- data1, data2  in  XLEN  rs1/rs2 operands.
- immediate, offset, ins_addr  in  XLEN  immediate, branch/memory offset, instruction PC.
- out_valid  out  1  result register valid.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- res  out  XLEN  ALU result / memory address / link value.
- write_reg, load_en, store_en  out  1  writeback, load, store enables.
- write_mem_data  out  XLEN  store data.
- jmp_en  out  1  redirect taken.
- jmp_addr  out  XLEN  redirect target.
- clr  out  1  younger-stage flush request.
- illegal  out  1  unknown optype.
- busy  out  1  multiply in progress.

Function
REQ-004 States IDLE and MUL; IDLE->MUL on accepted I_MUL/I_MULH; MUL->IDLE when iteration counter reaches MUL_CYCLES.
REQ-005 in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-006 Single-cycle ops: out_valid and all outputs registered on the edge after acceptance (latency 1).
REQ-007 I_MUL/I_MULH: shift-add on operand magnitudes, 2*XLEN-bit product, negated when operand signs differ; out_valid asserts exactly MUL_CYCLES edges after the accepting edge; busy=1 throughout MUL.
REQ-008 I_MUL res = product[XLEN-1:0]; I_MULH res = signed product[2*XLEN-1:XLEN].
REQ-009 ADD/ADDI/SUB/AND/OR/XOR: res = data1 op (data2 or immediate), modulo 2^XLEN; write_reg=1.
REQ-010 LUI res = immediate; AUIPC res = ins_addr + immediate; both write_reg=1.
REQ-011 LW: res = data1 + offset, load_en=1, write_reg=1. SW: res = data1 + offset, store_en=1, write_mem_data=data2.
REQ-012 BEQ/BNE equality; BLT/BGE true signed compare (no overflow error); taken -> jmp_en=1, clr=1, jmp_addr = ins_addr + offset; not taken -> jmp_en=0, jmp_addr=0, clr=0; write_reg=0.
REQ-013 JAL: res = ins_addr + 4, write_reg=1, jmp_en=1, clr=1, jmp_addr = ins_addr + offset.
REQ-014 Unknown optype: out_valid bubble with illegal=1, all enables 0, res=0.
REQ-015 While out_valid && !out_ready, every output holds stable.
REQ-016 Result leaves when out_valid && out_ready; a new single-cycle op may be accepted that same cycle (back-to-back throughput 1/cycle).
REQ-017 flush=1: state->IDLE, counter cleared, out_valid=0 next edge, in_valid that cycle ignored; flush dominates simultaneous acceptance and multiply completion.
REQ-018 jmp_en, clr, load_en, store_en, write_reg qualified: forced 0 when out_valid=0.

Reset
REQ-019 rst_n low: state=IDLE, counter=0, out_valid=0, all outputs 0, immediately and independent of clk.
REQ-020 Reset mid-multiply discards the operation; first accept allowed on first edge after rst_n rises.

Structure
REQ-021 I_* optype codes, state encoding and XLEN default belong in the shared instruction.vh package; no local redefinition.
REQ-022 One sub-module: seq_mul (iterative signed/unsigned multiplier, start/done handshake, parameters XLEN, MUL_BITS).

Verification
REQ-023 ADDI data1=5, immediate=-3 accepted -> next edge out_valid=1, res=2, write_reg=1.
REQ-024 MULH data1=0x80000000, data2=2 (XLEN=32, MUL_BITS=1) -> busy 32 cycles, res=0xFFFFFFFF, out_valid at edge 32.
REQ-025 BLT data1=0x7FFFFFFF, data2=0x80000000, ins_addr=0x100, offset=0x20 -> jmp_en=0; swapped operands -> jmp_en=1, clr=1, jmp_addr=0x120.
REQ-026 out_ready=0 for 3 cycles after ADD -> res held, in_ready=0; out_ready=1 with queued SUB -> SUB accepted same cycle.
REQ-027 flush at cycle 10 of MUL -> out_valid stays 0, in_ready=1 next cycle, following ADD completes correctly.
REQ-028 rst_n low during MUL -> outputs 0 asynchronously; JAL ins_addr=0x40 after release -> res=0x44, jmp_en=1.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared instruction codes, FSM state encoding and datapath defaults for the execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exec_unit_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OPW          = 5;

    // Instruction codes carried on optype; any other value is illegal.
    localparam logic [OPW-1:0] I_ADD   = 5'd0;
    localparam logic [OPW-1:0] I_ADDI  = 5'd1;
    localparam logic [OPW-1:0] I_SUB   = 5'd2;
    localparam logic [OPW-1:0] I_AND   = 5'd3;
    localparam logic [OPW-1:0] I_OR    = 5'd4;
    localparam logic [OPW-1:0] I_XOR   = 5'd5;
    localparam logic [OPW-1:0] I_LUI   = 5'd6;
    localparam logic [OPW-1:0] I_AUIPC = 5'd7;
    localparam logic [OPW-1:0] I_LW    = 5'd8;
    localparam logic [OPW-1:0] I_SW    = 5'd9;
    localparam logic [OPW-1:0] I_BEQ   = 5'd10;
    localparam logic [OPW-1:0] I_BNE   = 5'd11;
    localparam logic [OPW-1:0] I_BLT   = 5'd12;
    localparam logic [OPW-1:0] I_BGE   = 5'd13;
    localparam logic [OPW-1:0] I_JAL   = 5'd14;
    localparam logic [OPW-1:0] I_MUL   = 5'd15;
    localparam logic [OPW-1:0] I_MULH  = 5'd16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic [OPW-1:0] op);
        return (op == I_MUL) || (op == I_MULH);
    endfunction

endpackage

// File: rtl/exec_unit_seq_mul.sv
// Iterative shift-add multiplier on operand magnitudes, sign restored on the final product.
// Latency: done is high combinationally in the XLEN/MUL_BITS-th cycle after the start edge.
// Backpressure: none; the caller only starts it when idle and must take product on done.
module seq_mul #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic              sgn,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam int MUL_CYCLES = XLEN / MUL_BITS;
    localparam int CW         = $clog2(MUL_CYCLES + 1);

    logic              active_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] step;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    // Operand magnitudes; the most negative value maps to its correct unsigned magnitude.
    always_comb begin
        a_neg = sgn & a[XLEN-1];
        b_neg = sgn & b[XLEN-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration retires MUL_BITS multiplier bits; the last one feeds product directly.
    always_comb begin
        step = acc_q;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier_q[j]) begin
                step = step + (mcand_q << j);
            end
        end
    end

    assign done    = active_q && (cnt_q == CW'(MUL_CYCLES - 1));
    assign product = neg_q ? (~step + 1'b1) : step;

    // Iteration state: load on start, advance each cycle, drop out after the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (flush) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            neg_q    <= a_neg ^ b_neg;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
        end else if (active_q) begin
            acc_q    <= step;
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            if (done) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, address generation, branch resolution and iterative multiply.
// Latency: 1 cycle for single-cycle ops, XLEN/MUL_BITS cycles for MUL/MULH.
// Backpressure: one registered result; it holds while out_ready is low and blocks new ops.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  optype,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] ins_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            write_reg,
    output logic            load_en,
    output logic            store_en,
    output logic [XLEN-1:0] write_mem_data,
    output logic            jmp_en,
    output logic [XLEN-1:0] jmp_addr,
    output logic            clr,
    output logic            illegal,
    output logic            busy
);

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            write_reg;
        logic            load_en;
        logic            store_en;
        logic [XLEN-1:0] wdata;
        logic            jmp_en;
        logic [XLEN-1:0] jmp_addr;
        logic            clr;
        logic            illegal;
    } result_t;

    state_t            state_q;
    state_t            state_d;
    result_t           dec;
    result_t           mul_res;
    result_t           out_q;
    logic              accept;
    logic              start_mul;
    logic              mul_done;
    logic              mul_high_q;
    logic              taken;
    logic [2*XLEN-1:0] product;

    assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && is_mul_op(optype);

    seq_mul #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .start   (start_mul),
        .sgn     (1'b1),
        .a       (data1),
        .b       (data2),
        .done    (mul_done),
        .product (product)
    );

    // Single-cycle decode: everything the result register needs for a non-multiply op.
    always_comb begin
        dec   = '0;
        taken = 1'b0;
        case (optype)
            I_ADD:   begin dec.res = data1 + data2;         dec.write_reg = 1'b1; end
            I_ADDI:  begin dec.res = data1 + immediate;     dec.write_reg = 1'b1; end
            I_SUB:   begin dec.res = data1 - data2;         dec.write_reg = 1'b1; end
            I_AND:   begin dec.res = data1 & data2;         dec.write_reg = 1'b1; end
            I_OR:    begin dec.res = data1 | data2;         dec.write_reg = 1'b1; end
            I_XOR:   begin dec.res = data1 ^ data2;         dec.write_reg = 1'b1; end
            I_LUI:   begin dec.res = immediate;             dec.write_reg = 1'b1; end
            I_AUIPC: begin dec.res = ins_addr + immediate;  dec.write_reg = 1'b1; end
            I_LW: begin
                dec.res       = data1 + offset;
                dec.load_en   = 1'b1;
                dec.write_reg = 1'b1;
            end
            I_SW: begin
                dec.res      = data1 + offset;
                dec.store_en = 1'b1;
                dec.wdata    = data2;
            end
            I_BEQ, I_BNE, I_BLT, I_BGE: begin
                case (optype)
                    I_BEQ:   taken = (data1 == data2);
                    I_BNE:   taken = (data1 != data2);
                    I_BLT:   taken = ($signed(data1) <  $signed(data2));
                    default: taken = ($signed(data1) >= $signed(data2));
                endcase
                dec.jmp_en   = taken;
                dec.clr      = taken;
                dec.jmp_addr = taken ? (ins_addr + offset) : '0;
            end
            I_JAL: begin
                dec.res       = ins_addr + XLEN'(4);
                dec.write_reg = 1'b1;
                dec.jmp_en    = 1'b1;
                dec.clr       = 1'b1;
                dec.jmp_addr  = ins_addr + offset;
            end
            I_MUL, I_MULH: dec = '0;
            default: dec.illegal = 1'b1;
        endcase
    end

    // Multiply result selection once the iteration finishes.
    always_comb begin
        mul_res           = '0;
        mul_res.res       = mul_high_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
        mul_res.write_reg = 1'b1;
    end

    // Next state: enter MUL on an accepted multiply, leave on completion; flush wins.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_mul) state_d = ST_MUL;
                ST_MUL:  if (mul_done)  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register: load on accept or multiply completion, release on consume, kill on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            mul_high_q <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            if (is_mul_op(optype)) begin
                out_valid  <= 1'b0;
                mul_high_q <= (optype == I_MULH);
            end else begin
                out_valid <= 1'b1;
                out_q     <= dec;
            end
        end else if ((state_q == ST_MUL) && mul_done) begin
            out_valid <= 1'b1;
            out_q     <= mul_res;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign res            = out_q.res;
    assign write_mem_data = out_q.wdata;
    assign jmp_addr       = out_q.jmp_addr;
    assign write_reg      = out_valid & out_q.write_reg;
    assign load_en        = out_valid & out_q.load_en;
    assign store_en       = out_valid & out_q.store_en;
    assign jmp_en         = out_valid & out_q.jmp_en;
    assign clr            = out_valid & out_q.clr;
    assign illegal        = out_valid & out_q.illegal;
    assign busy           = (state_q == ST_MUL);

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: random and directed ops checked against an arithmetic model.
// Latency: n/a.
// Backpressure: out_ready is driven randomly or held low in directed sections.
module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      optype;
    logic [XLEN-1:0] data1, data2, immediate, offset, ins_addr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] res;
    logic            write_reg, load_en, store_en;
    logic [XLEN-1:0] write_mem_data;
    logic            jmp_en;
    logic [XLEN-1:0] jmp_addr;
    logic            clr, illegal, busy;

    exec_unit #(.XLEN(XLEN), .MUL_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .optype(optype),
        .data1(data1), .data2(data2), .immediate(immediate), .offset(offset), .ins_addr(ins_addr),
        .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .write_reg(write_reg), .load_en(load_en), .store_en(store_en),
        .write_mem_data(write_mem_data), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .clr(clr), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        bit          res_chk;
        logic [5:0]  flags;   // write_reg, load_en, store_en, jmp_en, clr, illegal
        logic [31:0] wdata;
        bit          wdata_chk;
        logic [31:0] jaddr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the instruction definitions.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] d1, d2, imm, off, pc);
        exp_t   e;
        longint p;
        bit     tk;
        e = '{default: '0};
        e.res_chk = 1;
        p = longint'($signed(d1)) * longint'($signed(d2));
        tk = 0;
        case (op)
            I_ADD:   begin e.res = d1 + d2;    e.flags = 6'b100000; end
            I_ADDI:  begin e.res = d1 + imm;   e.flags = 6'b100000; end
            I_SUB:   begin e.res = d1 - d2;    e.flags = 6'b100000; end
            I_AND:   begin e.res = d1 & d2;    e.flags = 6'b100000; end
            I_OR:    begin e.res = d1 | d2;    e.flags = 6'b100000; end
            I_XOR:   begin e.res = d1 ^ d2;    e.flags = 6'b100000; end
            I_LUI:   begin e.res = imm;        e.flags = 6'b100000; end
            I_AUIPC: begin e.res = pc + imm;   e.flags = 6'b100000; end
            I_LW:    begin e.res = d1 + off;   e.flags = 6'b110000; end
            I_SW: begin
                e.res = d1 + off; e.flags = 6'b001000; e.wdata = d2; e.wdata_chk = 1;
            end
            I_BEQ, I_BNE, I_BLT, I_BGE: begin
                if (op == I_BEQ) tk = (d1 == d2);
                if (op == I_BNE) tk = (d1 != d2);
                if (op == I_BLT) tk = ($signed(d1) <  $signed(d2));
                if (op == I_BGE) tk = ($signed(d1) >= $signed(d2));
                e.res_chk = 0;
                e.flags   = tk ? 6'b000110 : 6'b000000;
                e.jaddr   = tk ? pc + off : 32'h0;
            end
            I_JAL:  begin e.res = pc + 32'd4; e.flags = 6'b100110; e.jaddr = pc + off; end
            I_MUL:  begin e.res = p[31:0];    e.flags = 6'b100000; end
            I_MULH: begin e.res = p[63:32];   e.flags = 6'b100000; end
            default: begin e.res = 32'h0;     e.flags = 6'b000001; end
        endcase
        return e;
    endfunction

    // Offer one op from a posedge+1 point; return after the accepting edge (+1) with cycles waited.
    task automatic issue(input logic [4:0] op, input logic [31:0] d1, d2, imm, off, pc,
                         output int waited);
        bit hs;
        optype = op; data1 = d1; data2 = d2; immediate = imm; offset = off; ins_addr = pc;
        in_valid = 1'b1;
        waited = 0;
        hs = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!hs && waited < 200);
        in_valid = 1'b0;
        if (!hs) check("issue timeout", 64'd0, 64'd1);
        else sb.push_back(model(op, d1, d2, imm, off, pc));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Randomised consumer backpressure.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop and compare on every handshake; check hold stability and enable qualification.
    exp_t        mon_e;
    bit          hold_v = 0;
    logic [31:0] h_res, h_wdata, h_jaddr;
    logic [5:0]  h_flags;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("hold res", res, h_res);
                check("hold flags", {write_reg, load_en, store_en, jmp_en, clr, illegal}, h_flags);
                check("hold jmp_addr", jmp_addr, h_jaddr);
                check("hold wdata", write_mem_data, h_wdata);
                check("hold valid", out_valid, 1'b1);
            end
            if (!out_valid)
                check("qualified enables", {write_reg, load_en, store_en, jmp_en, clr, illegal}, 6'b0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious result", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.res_chk) check("res", res, mon_e.res);
                    check("flags", {write_reg, load_en, store_en, jmp_en, clr, illegal}, mon_e.flags);
                    check("jmp_addr", jmp_addr, mon_e.jaddr);
                    if (mon_e.wdata_chk) check("write_mem_data", write_mem_data, mon_e.wdata);
                end
            end
            hold_v  = out_valid && !out_ready && !flush;
            h_res   = res;
            h_wdata = write_mem_data;
            h_jaddr = jmp_addr;
            h_flags = {write_reg, load_en, store_en, jmp_en, clr, illegal};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [4:0] op;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; optype = '0; out_ready = 1'b1;
        data1 = '0; data2 = '0; immediate = '0; offset = '0; ins_addr = '0;

        // Reset state.
        #12;
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset res", res, 32'h0);
        check("reset in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        // ADDI 5 + (-3), latency 1.
        issue(I_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 32'd0, w);
        check("addi out_valid", out_valid, 1'b1);
        check("addi res", res, 32'd2);
        check("addi write_reg", write_reg, 1'b1);

        // MULH 0x80000000 * 2: busy for 32 cycles, result at edge 32.
        issue(I_MULH, 32'h8000_0000, 32'd2, 32'd0, 32'd0, 32'd0, w);
        check("mulh busy start", busy, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            if (k < 32) begin
                check("mulh early valid", out_valid, 1'b0);
                check("mulh busy", busy, 1'b1);
            end else begin
                check("mulh valid at 32", out_valid, 1'b1);
                check("mulh res", res, 32'hFFFF_FFFF);
                check("mulh busy end", busy, 1'b0);
            end
        end

        // BLT: signed compare without overflow artefacts.
        issue(I_BLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h20, 32'h100, w);
        check("blt not taken", jmp_en, 1'b0);
        issue(I_BLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'h20, 32'h100, w);
        check("blt taken jmp_en", jmp_en, 1'b1);
        check("blt taken clr", clr, 1'b1);
        check("blt taken jmp_addr", jmp_addr, 32'h120);

        // Backpressure hold then same-cycle accept of the next op.
        issue(I_ADD, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0, w);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall out_valid", out_valid, 1'b1);
            check("stall in_ready", in_ready, 1'b0);
            check("stall res", res, 32'd30);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(I_SUB, 32'd50, 32'd8, 32'd0, 32'd0, 32'd0, w);
        check("sub same-cycle accept", w, 1);
        check("sub res", res, 32'd42);

        // Flush on cycle 10 of a multiply; an op offered during the flush must be dropped.
        issue(I_MUL, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, w);
        cyc(9);
        flush = 1'b1;
        optype = I_ADD; data1 = 32'd1; data2 = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        check("flush in_ready", in_ready, 1'b0);
        cyc(1);
        flush = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_back());
        check("flush out_valid", out_valid, 1'b0);
        check("flush busy", busy, 1'b0);
        @(negedge clk);
        check("post-flush in_ready", in_ready, 1'b1);
        cyc(40);
        issue(I_ADD, 32'd7, 32'd8, 32'd0, 32'd0, 32'd0, w);
        check("post-flush add res", res, 32'd15);

        // Asynchronous reset mid-multiply.
        issue(I_MUL, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, w);
        cyc(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy", busy, 1'b0);
        check("async reset out_valid", out_valid, 1'b0);
        check("async reset res", res, 32'h0);
        sb.delete();
        cyc(2);
        rst_n = 1'b1;
        issue(I_JAL, 32'd0, 32'd0, 32'd0, 32'h10, 32'h40, w);
        check("jal first-edge accept", w, 1);
        check("jal res", res, 32'h44);
        check("jal jmp_en", jmp_en, 1'b1);
        check("jal jmp_addr", jmp_addr, 32'h50);

        // Random traffic with random backpressure.
        rand_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            cyc($urandom_range(0, 2));
            case ($urandom_range(0, 18))
                17, 18:  op = 5'($urandom_range(17, 31));
                default: op = 5'($urandom_range(0, 16));
            endcase
            issue(op, rnd(), rnd(), rnd(), rnd(), rnd(), w);
        end
        rand_rdy = 0;
        cyc(1);
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sb.size() != 0; t++) cyc(1);
        check("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
